// File: rtl/dram_ctrl.sv
// Single-outstanding DRAM command controller with an open-page policy.
// Turns word read/write requests into precharge/activate/column command sequences.
module dram_ctrl #(
   parameter int ROW_W  = 11,
   parameter int COL_W  = 10,
   parameter int DATA_W = 32,
   parameter int T_RP   = 5,
   parameter int T_RCD  = 5,
   parameter int T_CL   = 5,
   localparam int A_W   = (ROW_W > COL_W) ? ROW_W : COL_W
) (
   input  logic                   CK,
   input  logic                   RSTn,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ROW_W+COL_W-1:0] req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   input  logic [3:0]             req_wstrb,
   output logic                   rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   DRAM_CSn,
   output logic                   DRAM_RASn,
   output logic                   DRAM_CASn,
   output logic [3:0]             DRAM_WEn,
   output logic [A_W-1:0]         DRAM_A,
   output logic [DATA_W-1:0]      DRAM_D,
   input  logic [DATA_W-1:0]      DRAM_Q,
   input  logic                   DRAM_VALID
);

   typedef enum logic [2:0] {
      IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, COL, COL_WAIT, RESP
   } state_t;

   state_t                   state, state_d;
   logic [2:0]               cnt, cnt_d;
   logic                     row_open, row_open_d;
   logic [ROW_W-1:0]         open_row, open_row_d;
   logic                     lat_write;
   logic [ROW_W+COL_W-1:0]   lat_addr;
   logic [DATA_W-1:0]        lat_wdata;
   logic [3:0]               lat_wstrb;
   logic                     accept;
   logic                     ras_d, cas_d, ready_d, rsp_valid_d;
   logic [3:0]               wen_d;
   logic [A_W-1:0]           a_d;
   logic [DATA_W-1:0]        d_d, rdata_d;
   logic [ROW_W-1:0]         req_row, lat_row;
   logic [COL_W-1:0]         lat_col;

   assign req_row = req_addr[ROW_W+COL_W-1:COL_W];
   assign lat_row = lat_addr[ROW_W+COL_W-1:COL_W];
   assign lat_col = lat_addr[COL_W-1:0];
   assign accept  = req_valid & req_ready;

   // Next state plus the next value of every registered bus/response output.
   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      row_open_d  = row_open;
      open_row_d  = open_row;
      ras_d       = 1'b1;
      cas_d       = 1'b1;
      wen_d       = 4'hf;
      a_d         = '0;
      d_d         = DRAM_D;
      ready_d     = 1'b0;
      rsp_valid_d = 1'b0;
      rdata_d     = rsp_rdata;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_write && req_wstrb == 4'h0)       state_d = COL;
               else if (row_open && req_row == open_row) state_d = COL;
               else if (row_open)                        state_d = PRE;
               else                                      state_d = ACT;
            end else begin
               ready_d = 1'b1;
            end
         end
         PRE: begin
            ras_d               = 1'b0;
            wen_d               = 4'h0;
            a_d[ROW_W-1:0]      = open_row;
            row_open_d          = 1'b0;
            cnt_d               = 3'(T_RP - 2);
            state_d             = PRE_WAIT;
         end
         PRE_WAIT: begin
            if (cnt == 3'd0) state_d = ACT;
            else             cnt_d   = cnt - 3'd1;
         end
         ACT: begin
            ras_d               = 1'b0;
            a_d[ROW_W-1:0]      = lat_row;
            row_open_d          = 1'b1;
            open_row_d          = lat_row;
            cnt_d               = 3'(T_RCD - 2);
            state_d             = ACT_WAIT;
         end
         ACT_WAIT: begin
            if (cnt == 3'd0) state_d = COL;
            else             cnt_d   = cnt - 3'd1;
         end
         COL: begin
            // An all-zero strobe write has nothing to store; a column command
            // with WEn all high would be a read, so it is skipped entirely.
            if (lat_write && lat_wstrb == 4'h0) begin
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cas_d          = 1'b0;
               a_d[COL_W-1:0] = lat_col;
               wen_d          = lat_write ? ~lat_wstrb : 4'hf;
               if (lat_write) d_d = lat_wdata;
               cnt_d          = 3'(T_CL - 1);
               state_d        = COL_WAIT;
            end
         end
         COL_WAIT: begin
            if (cnt != 3'd0) cnt_d = cnt - 3'd1;
            if (lat_write) begin
               if (cnt == 3'd0) begin
                  rsp_valid_d = 1'b1;
                  state_d     = RESP;
               end
            end else if (DRAM_VALID) begin
               rsp_valid_d = 1'b1;
               rdata_d     = DRAM_Q;
               state_d     = RESP;
            end
         end
         RESP: begin
            d_d     = '0;
            ready_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CK or negedge RSTn) begin
      if (!RSTn) begin
         state     <= IDLE;
         cnt       <= '0;
         row_open  <= 1'b0;
         open_row  <= '0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
         DRAM_CSn  <= 1'b1;
         DRAM_RASn <= 1'b1;
         DRAM_CASn <= 1'b1;
         DRAM_WEn  <= 4'hf;
         DRAM_A    <= '0;
         DRAM_D    <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         row_open  <= row_open_d;
         open_row  <= open_row_d;
         if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
         end
         DRAM_CSn  <= 1'b0;
         DRAM_RASn <= ras_d;
         DRAM_CASn <= cas_d;
         DRAM_WEn  <= wen_d;
         DRAM_A    <= a_d;
         DRAM_D    <= d_d;
         req_ready <= ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_rdata <= rdata_d;
      end
   end

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: behavioural DRAM model, directed requests, and
// scoreboard queues for expected commands and responses checked by monitors.
module tb_dram_ctrl;

   localparam int HIT = 0, COLD = 1, MISS = 2, SKIP = 3;

   logic        CK = 1'b0;
   logic        RSTn;
   logic        req_valid, req_ready, req_write;
   logic [20:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
   logic [3:0]  DRAM_WEn;
   logic [10:0] DRAM_A;
   logic [31:0] DRAM_D;
   logic [31:0] DRAM_Q;
   logic        DRAM_VALID;

   dram_ctrl dut (
      .CK(CK), .RSTn(RSTn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .DRAM_CSn(DRAM_CSn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn),
      .DRAM_WEn(DRAM_WEn), .DRAM_A(DRAM_A), .DRAM_D(DRAM_D),
      .DRAM_Q(DRAM_Q), .DRAM_VALID(DRAM_VALID)
   );

   always #5 CK = ~CK;

   int cyc = 0;
   always @(posedge CK) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   typedef struct { int cyc; int typ; logic [10:0] a; logic [3:0] wen; } cmd_t;
   typedef struct { int acc; int lat; bit rd; logic [31:0] data; } rsp_t;
   cmd_t cq[$];
   rsp_t rq[$];

   // DRAM model: CAS sampled at edge S, read data strobed for edge S+4,
   // write data taken from DRAM_D at edge S+4.
   logic [31:0] mem [0:8191];
   logic [10:0] act_row;
   logic        act_valid;
   int          rd_cnt, wr_cnt;
   logic [12:0] rd_idx, wr_idx;
   logic [3:0]  wr_wen;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] wen);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (!wen[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   initial for (int i = 0; i < 8192; i++) mem[i] = 32'h0;

   always @(posedge CK or negedge RSTn) begin
      if (!RSTn) begin
         act_valid  <= 1'b0;
         act_row    <= '0;
         rd_cnt     <= 0;
         wr_cnt     <= 0;
         DRAM_VALID <= 1'b0;
         DRAM_Q     <= '0;
      end else begin
         DRAM_VALID <= 1'b0;
         if (rd_cnt != 0) begin
            rd_cnt <= rd_cnt - 1;
            if (rd_cnt == 1) begin
               DRAM_VALID <= 1'b1;
               DRAM_Q     <= mem[rd_idx];
            end
         end
         if (wr_cnt != 0) begin
            wr_cnt <= wr_cnt - 1;
            if (wr_cnt == 1) mem[wr_idx] <= merge(mem[wr_idx], DRAM_D, wr_wen);
         end
         if (!DRAM_CSn && !DRAM_RASn && DRAM_CASn) begin
            if (DRAM_WEn == 4'hf) begin
               act_row   <= DRAM_A;
               act_valid <= 1'b1;
            end else begin
               act_valid <= 1'b0;
            end
         end
         if (!DRAM_CSn && DRAM_RASn && !DRAM_CASn) begin
            if (DRAM_WEn == 4'hf) begin
               rd_cnt <= 3;
               rd_idx <= {act_row[2:0], DRAM_A[9:0]};
            end else begin
               wr_cnt <= 4;
               wr_idx <= {act_row[2:0], DRAM_A[9:0]};
               wr_wen <= DRAM_WEn;
            end
         end
      end
   end

   // Command monitor: every command must match the next expected one.
   int last_col = -100;
   always @(negedge CK) begin
      if (RSTn) begin
         if (!DRAM_RASn || !DRAM_CASn) begin
            int   typ;
            cmd_t e;
            typ = !DRAM_RASn ? ((DRAM_WEn == 4'hf) ? 1 : 0) : 2;
            if (typ == 0) begin
               chk("pre_row_is_open", {act_valid, DRAM_A}, {1'b1, act_row});
            end
            if (typ == 2) begin
               chk("col_row_is_open", act_valid, 1'b1);
               chk("cas_spacing_ok", (cyc - last_col) >= 5, 1'b1);
               last_col = cyc;
            end
            if (cq.size() == 0) begin
               chk("cmd_unexpected", typ, 99);
            end else begin
               e = cq.pop_front();
               chk("cmd_cycle", cyc, e.cyc);
               chk("cmd_type", typ, e.typ);
               chk("cmd_A", DRAM_A, e.a);
               chk("cmd_WEn", DRAM_WEn, e.wen);
            end
         end else begin
            chk("idle_bus", {DRAM_CSn, DRAM_WEn, DRAM_A}, {1'b0, 4'hf, 11'h0});
         end
      end
   end

   // Response monitor.
   always @(negedge CK) begin
      if (RSTn && rsp_valid) begin
         rsp_t e;
         if (rq.size() == 0) begin
            chk("rsp_unexpected", 1'b1, 1'b0);
         end else begin
            e = rq.pop_front();
            chk("rsp_latency", cyc - e.acc, e.lat);
            if (e.rd) chk("rsp_rdata", rsp_rdata, e.data);
         end
      end
   end

   task automatic send(input bit wr, input logic [20:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int kind, input logic [10:0] prev_row,
                       input logic [31:0] exp);
      int          n, acc, lat;
      logic [3:0]  wen;
      logic [10:0] row, col;
      @(negedge CK);
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = strb;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 60) begin
         @(negedge CK);
         n++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 1'b0, 1'b1);
         req_valid = 1'b0;
         return;
      end
      acc = cyc + 1;
      row = addr[20:10];
      col = {1'b0, addr[9:0]};
      wen = wr ? ~strb : 4'hf;
      case (kind)
         HIT:  begin
            lat = 6;
            cq.push_back('{acc + 1, 2, col, wen});
         end
         COLD: begin
            lat = 11;
            cq.push_back('{acc + 1, 1, row, 4'hf});
            cq.push_back('{acc + 6, 2, col, wen});
         end
         MISS: begin
            lat = 16;
            cq.push_back('{acc + 1, 0, prev_row, 4'h0});
            cq.push_back('{acc + 6, 1, row, 4'hf});
            cq.push_back('{acc + 11, 2, col, wen});
         end
         default: lat = 1;
      endcase
      rq.push_back('{acc, lat, !wr, exp});
      @(posedge CK);
      #1;
   endtask

   task automatic drain();
      int n;
      req_valid = 1'b0;
      n = 0;
      while ((rq.size() != 0 || cq.size() != 0) && n < 100) begin
         @(negedge CK);
         n++;
      end
      chk("drain_pending", rq.size() + cq.size(), 0);
      @(negedge CK);
   endtask

   task automatic chk_reset_vals(input string name);
      chk(name, {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, req_ready, rsp_valid},
          {1'b1, 1'b1, 1'b1, 4'hf, 11'h0, 1'b0, 1'b0});
      chk({name, "_data"}, {rsp_rdata, DRAM_D}, 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw;
      RSTn      = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
      repeat (3) @(negedge CK);
      chk_reset_vals("reset_state");
      #1 RSTn = 1'b1;
      @(negedge CK);
      chk("first_cycle_cs_ready", {DRAM_CSn, req_ready}, {1'b0, 1'b1});

      send(0, 21'h000123, 32'h0, 4'h0, COLD, 11'h0, 32'h0);                 drain();
      send(1, 21'h000010, 32'hDEADBEEF, 4'hf, HIT, 11'h0, 32'h0);            drain();
      send(0, 21'h000010, 32'h0, 4'h0, HIT, 11'h0, 32'hDEADBEEF);            drain();
      send(1, 21'h000010, 32'h11223344, 4'b0101, HIT, 11'h0, 32'h0);         drain();
      send(0, 21'h000010, 32'h0, 4'h0, HIT, 11'h0, 32'hDE22BE44);            drain();
      send(1, 21'h000405, 32'hCAFEF00D, 4'hf, MISS, 11'h000, 32'h0);         drain();
      send(0, 21'h000807, 32'h0, 4'h0, MISS, 11'h001, 32'h0);                drain();
      send(0, 21'h000405, 32'h0, 4'h0, MISS, 11'h002, 32'hCAFEF00D);         drain();

      for (int i = 0; i < 4; i++)
         send(1, 21'h000400 + 21'(i), 32'h100 + 32'(i), 4'hf, HIT, 11'h0, 32'h0);
      for (int i = 0; i < 4; i++)
         send(0, 21'h000400 + 21'(i), 32'h0, 4'h0, HIT, 11'h0, 32'h100 + 32'(i));
      drain();

      send(1, 21'h000400, 32'hFFFFFFFF, 4'h0, SKIP, 11'h0, 32'h0);           drain();
      send(0, 21'h000400, 32'h0, 4'h0, HIT, 11'h0, 32'h100);                 drain();

      // Reset while the controller sits in ACT_WAIT of a row-miss read.
      send(0, 21'h000C09, 32'h0, 4'h0, MISS, 11'h001, 32'h0);
      req_valid = 1'b0;
      repeat (7) @(posedge CK);
      #1 RSTn = 1'b0;
      cq.delete();
      rq.delete();
      @(negedge CK);
      chk_reset_vals("reset_mid_sequence");
      @(negedge CK);
      #1 RSTn = 1'b1;
      saw = 1'b0;
      @(negedge CK);
      chk("after_reset_cs_ready", {DRAM_CSn, req_ready}, {1'b0, 1'b1});
      for (int i = 0; i < 20; i++) begin
         if (rsp_valid) saw = 1'b1;
         @(negedge CK);
      end
      chk("dropped_request_no_rsp", saw, 1'b0);
      send(0, 21'h000401, 32'h0, 4'h0, COLD, 11'h0, 32'h101);                drain();

      chk("queues_empty_at_end", rq.size() + cq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
